// File: rtl/cpu_clk_ratio_pkg.sv
// ---------------------------------------------------------------------------
// cpu_clk_ratio_pkg - shared register map and ratio constants.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_clk_ratio_pkg;

  localparam int RATIO_W = 3;
  localparam logic [RATIO_W-1:0] RESET_RATIO = '0;

  // APB byte offsets; only bits [3:2] select a register
  localparam logic [3:0] RATIO_OFS  = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] PCNT_OFS   = 4'h8;

  function automatic logic [1:0] reg_idx(input logic [3:0] ofs);
    return ofs[3:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_ratio_div.sv
// ---------------------------------------------------------------------------
// clk_ratio_div - period counter, boundary-aligned ratio apply, enable strobe.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clk_ratio_div
  import cpu_clk_ratio_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [RATIO_W-1:0] pend_ratio,
  input  logic               pend_vld,
  input  logic               gate_en,
  output logic               clk_en,
  output logic               apply_ack,
  output logic               ratio_upd,
  output logic [RATIO_W-1:0] cur_ratio
);

  logic [RATIO_W-1:0] cnt;
  logic               boundary;

  assign boundary  = (cnt == cur_ratio);
  assign apply_ack = boundary && pend_vld;
  // Gating masks only the strobe; the period keeps running underneath
  assign clk_en    = boundary && !gate_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      cur_ratio <= RESET_RATIO;
      ratio_upd <= 1'b0;
    end else begin
      ratio_upd <= apply_ack;
      if (boundary) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + RATIO_W'(1);
      end
      if (apply_ack) begin
        cur_ratio <= pend_ratio;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_clk_ratio_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_clk_ratio_ctrl - APB clock-ratio controller with enable-pulse counter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_clk_ratio_ctrl
  import cpu_clk_ratio_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        cpu_clk,
  input  logic        clkrst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  input  logic        gate_en,
  output logic        clk_en,
  output logic        ratio_upd
);

  logic [RATIO_W-1:0] pend_ratio;
  logic               pend_vld;
  logic [RATIO_W-1:0] cur_ratio;
  logic               apply_ack;
  logic [CNT_W-1:0]   pulse_cnt;
  logic               wr;
  logic               wr_ratio;
  logic               wr_pcnt;
  logic               unused_bits;

  assign wr       = psel && penable && pwrite;
  assign wr_ratio = wr && (paddr[3:2] == reg_idx(RATIO_OFS));
  assign wr_pcnt  = wr && (paddr[3:2] == reg_idx(PCNT_OFS));

  assign unused_bits = ^{pwdata[31:RATIO_W], paddr[1:0]};

  clk_ratio_div u_div (
    .clk        (cpu_clk),
    .rst        (clkrst),
    .pend_ratio (pend_ratio),
    .pend_vld   (pend_vld),
    .gate_en    (gate_en),
    .clk_en     (clk_en),
    .apply_ack  (apply_ack),
    .ratio_upd  (ratio_upd),
    .cur_ratio  (cur_ratio)
  );

  // A write landing on an apply cycle replaces the pending value, so it wins
  always_ff @(posedge cpu_clk) begin
    if (clkrst) begin
      pend_ratio <= RESET_RATIO;
      pend_vld   <= 1'b0;
    end else if (wr_ratio) begin
      pend_ratio <= pwdata[RATIO_W-1:0];
      pend_vld   <= 1'b1;
    end else if (apply_ack) begin
      pend_vld   <= 1'b0;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (clkrst || wr_pcnt) begin
      pulse_cnt <= '0;
    end else if (clk_en) begin
      pulse_cnt <= pulse_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (paddr[3:2])
        reg_idx(RATIO_OFS):  prdata = 32'(cur_ratio);
        reg_idx(STATUS_OFS): prdata = {27'b0, pend_vld, pend_ratio, 1'b0};
        reg_idx(PCNT_OFS):   prdata = 32'(pulse_cnt);
        default:             prdata = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_clk_ratio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_clk_ratio_ctrl - directed self-checking bench for cpu_clk_ratio_ctrl.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cpu_clk_ratio_ctrl;

  logic        cpu_clk = 1'b0;
  logic        clkrst  = 1'b1;
  logic        psel    = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [3:0]  paddr   = '0;
  logic [31:0] pwdata  = '0;
  logic [31:0] prdata;
  logic        gate_en = 1'b0;
  logic        clk_en;
  logic        ratio_upd;

  int total  = 0;
  int passed = 0;

  cpu_clk_ratio_ctrl #(.CNT_W(16)) dut (
    .cpu_clk   (cpu_clk),
    .clkrst    (clkrst),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .gate_en   (gate_en),
    .clk_en    (clk_en),
    .ratio_upd (ratio_upd)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Inputs change and outputs are sampled only around the falling edge
  task automatic step(input int n);
    repeat (n) @(negedge cpu_clk);
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge cpu_clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    #1;
    d = prdata;
    psel = 1'b0;
  endtask

  task automatic wait_upd(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (ratio_upd === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) $display("FAIL %s: ratio_upd got 0 within 12 cycles, expected 1", name);
    else passed++;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    clkrst = 1'b1;
    step(2);
    total++;
    if (clk_en !== 1'b1) $display("FAIL rst_clk_en: got %b expected 1", clk_en); else passed++;
    total++;
    if (ratio_upd !== 1'b0) $display("FAIL rst_ratio_upd: got %b expected 0", ratio_upd); else passed++;
    total++;
    if (prdata !== 32'h0) $display("FAIL rst_prdata_idle: got %h expected 0", prdata); else passed++;
    apb_read(4'h0, rd);
    total++;
    if (rd !== 32'h0) $display("FAIL rst_ratio: got %h expected 0", rd); else passed++;
    apb_read(4'h4, rd);
    total++;
    if (rd !== 32'h0) $display("FAIL rst_status: got %h expected 0", rd); else passed++;
    apb_read(4'h8, rd);
    total++;
    if (rd !== 32'h0) $display("FAIL rst_pcnt: got %h expected 0", rd); else passed++;
    clkrst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (clk_en !== 1'b1) $display("FAIL full_speed_clk_en[%0d]: got %b expected 1", i, clk_en);
      else passed++;
      step(1);
    end
    apb_read(4'h8, rd);
    total++;
    if (rd !== 32'd10) $display("FAIL full_speed_pcnt: got %0d expected 10", rd); else passed++;
  endtask

  task automatic test_ratio3();
    logic [31:0] rd;
    apb_write(4'h0, 32'd3);
    apb_read(4'h4, rd);
    total++;
    if (rd !== 32'h16) $display("FAIL r3_status_pend: got %h expected 16", rd); else passed++;
    total++;
    if (ratio_upd !== 1'b0) $display("FAIL r3_no_upd_in_write: got %b expected 0", ratio_upd); else passed++;
    step(1);
    total++;
    if (ratio_upd !== 1'b1) $display("FAIL r3_upd: got %b expected 1", ratio_upd); else passed++;
    apb_read(4'h0, rd);
    total++;
    if (rd !== 32'd3) $display("FAIL r3_ratio_read: got %0d expected 3", rd); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (clk_en !== ((i % 4) == 3))
        $display("FAIL r3_clk_en[%0d]: got %b expected %b", i, clk_en, ((i % 4) == 3));
      else passed++;
      step(1);
    end
    total++;
    if (ratio_upd !== 1'b0) $display("FAIL r3_upd_one_cycle: got %b expected 0", ratio_upd); else passed++;
    apb_read(4'h4, rd);
    total++;
    if (rd !== 32'h06) $display("FAIL r3_status_clear: got %h expected 06", rd); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    apb_write(4'h0, 32'd7);
    wait_upd("b2b_apply7");
    total++;
    if (clk_en !== 1'b0) $display("FAIL b2b_cnt0_clk_en: got %b expected 0", clk_en); else passed++;
    step(2);
    apb_write(4'h0, 32'd2);
    step(4);
    total++;
    if (clk_en !== 1'b1) $display("FAIL b2b_boundary7: got %b expected 1", clk_en); else passed++;
    apb_write(4'h0, 32'd5);
    total++;
    if (ratio_upd !== 1'b1) $display("FAIL b2b_upd2: got %b expected 1", ratio_upd); else passed++;
    apb_read(4'h4, rd);
    total++;
    if (rd !== 32'h1A) $display("FAIL b2b_status5: got %h expected 1a", rd); else passed++;
    apb_read(4'h0, rd);
    total++;
    if (rd !== 32'd2) $display("FAIL b2b_ratio2: got %0d expected 2", rd); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (clk_en !== (i == 2)) $display("FAIL b2b_r2_clk_en[%0d]: got %b expected %b", i, clk_en, (i == 2));
      else passed++;
      step(1);
    end
    total++;
    if (ratio_upd !== 1'b1) $display("FAIL b2b_upd5: got %b expected 1", ratio_upd); else passed++;
    apb_read(4'h0, rd);
    total++;
    if (rd !== 32'd5) $display("FAIL b2b_ratio5: got %0d expected 5", rd); else passed++;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (clk_en !== ((i % 6) == 5))
        $display("FAIL b2b_r5_clk_en[%0d]: got %b expected %b", i, clk_en, ((i % 6) == 5));
      else passed++;
      step(1);
    end
  endtask

  task automatic test_gate();
    logic [31:0] rd;
    apb_write(4'h0, 32'd1);
    wait_upd("gate_apply1");
    apb_write(4'h8, 32'h0);
    gate_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      total++;
      if (clk_en !== 1'b0) $display("FAIL gate_masked[%0d]: got %b expected 0", i, clk_en); else passed++;
      step(1);
    end
    apb_read(4'h8, rd);
    total++;
    if (rd !== 32'd0) $display("FAIL gate_pcnt_frozen: got %0d expected 0", rd); else passed++;
    gate_en = 1'b0;
    #1;
    total++;
    if (clk_en !== 1'b1) $display("FAIL gate_release_phase: got %b expected 1", clk_en); else passed++;
    step(1);
    total++;
    if (clk_en !== 1'b0) $display("FAIL gate_release_next: got %b expected 0", clk_en); else passed++;
    apb_read(4'h8, rd);
    total++;
    if (rd !== 32'd1) $display("FAIL gate_pcnt_after: got %0d expected 1", rd); else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    apb_write(4'h0, 32'd0);
    wait_upd("wrap_apply0");
    force dut.pulse_cnt = 16'hFFFF;
    #1;
    release dut.pulse_cnt;
    apb_read(4'h8, rd);
    total++;
    if (rd !== 32'h0000FFFF) $display("FAIL wrap_preload: got %h expected 0000ffff", rd); else passed++;
    step(1);
    apb_read(4'h8, rd);
    total++;
    if (rd !== 32'h0) $display("FAIL wrap_to_zero: got %h expected 0", rd); else passed++;
    step(3);
    apb_read(4'h8, rd);
    total++;
    if (rd !== 32'd3) $display("FAIL wrap_count3: got %0d expected 3", rd); else passed++;
    apb_write(4'h8, 32'h1234);
    apb_read(4'h8, rd);
    total++;
    if (rd !== 32'h0) $display("FAIL clear_beats_inc: got %h expected 0", rd); else passed++;
    // Setup-phase write (no penable) must not commit, and prdata stays 0 on writes
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 4'h8;
    #1;
    total++;
    if (prdata !== 32'h0) $display("FAIL prdata_on_write: got %h expected 0", prdata); else passed++;
    step(1);
    psel = 1'b0; pwrite = 1'b0;
    apb_read(4'h8, rd);
    total++;
    if (rd !== 32'd1) $display("FAIL no_commit_wo_penable: got %0d expected 1", rd); else passed++;
    apb_write(4'hC, 32'd7);
    apb_read(4'hC, rd);
    total++;
    if (rd !== 32'h0) $display("FAIL rsvd_read: got %h expected 0", rd); else passed++;
    apb_read(4'h4, rd);
    total++;
    if (rd !== 32'h0) $display("FAIL rsvd_write_ignored: got %h expected 0", rd); else passed++;
    apb_write(4'h0, 32'd0);
    wait_upd("same_ratio_upd");
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    apb_write(4'h0, 32'd4);
    wait_upd("mid_apply4");
    apb_write(4'h0, 32'd6);
    apb_read(4'h4, rd);
    total++;
    if (rd !== 32'h1C) $display("FAIL mid_status6: got %h expected 1c", rd); else passed++;
    clkrst = 1'b1;
    step(1);
    total++;
    if (clk_en !== 1'b1) $display("FAIL mid_rst_clk_en: got %b expected 1", clk_en); else passed++;
    apb_read(4'h0, rd);
    total++;
    if (rd !== 32'h0) $display("FAIL mid_rst_ratio: got %h expected 0", rd); else passed++;
    apb_read(4'h4, rd);
    total++;
    if (rd !== 32'h0) $display("FAIL mid_rst_status: got %h expected 0", rd); else passed++;
    apb_read(4'h8, rd);
    total++;
    if (rd !== 32'h0) $display("FAIL mid_rst_pcnt: got %h expected 0", rd); else passed++;
    clkrst = 1'b0;
    step(1);
    total++;
    if (clk_en !== 1'b1) $display("FAIL mid_post_clk_en: got %b expected 1", clk_en); else passed++;
    apb_read(4'h4, rd);
    total++;
    if (rd !== 32'h0) $display("FAIL mid_post_status: got %h expected 0", rd); else passed++;
    apb_read(4'h8, rd);
    total++;
    if (rd !== 32'd1) $display("FAIL mid_post_pcnt: got %0d expected 1", rd); else passed++;
    step(1);
    total++;
    if (clk_en !== 1'b1 || ratio_upd !== 1'b0)
      $display("FAIL mid_discarded: got clk_en=%b upd=%b expected clk_en=1 upd=0", clk_en, ratio_upd);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_ratio3();
    test_back_to_back();
    test_gate();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
